// File: rtl/mem_arbiter_if.sv
// Requester, RAM and status bundle for mem_arbiter.
// slave = arbiter side, master = requesters/RAM/environment side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              p0_req,   p1_req;
  logic              p0_we,    p1_we;
  logic [ADDR_W-1:0] p0_addr,  p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt,   p1_gnt;
  logic              p0_done,  p1_done;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_write;
  logic              ram_select;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, ram_rdata,
    output p0_gnt, p1_gnt, p0_done, p1_done, rdata,
           ram_addr, ram_wdata, ram_write, ram_select, busy
  );

  modport master (
    output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr, p0_wdata, p1_wdata, ram_rdata,
    input  p0_gnt, p1_gnt, p0_done, p1_done, rdata,
           ram_addr, ram_wdata, ram_write, ram_select, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester single-port RAM arbiter: IDLE -> ACCESS -> RESP, one access per 3 cycles.
// Define ROUND_ROBIN_EN for alternating priority on contention; otherwise p0 always wins.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic           clock,
  input  logic           reset_n,
  mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e            state_q;
  logic [1:0]        gnt_q, done_q;
  logic              win_q, win_d;       // 1 = requester 1
  logic              ram_sel_q, ram_wr_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q, rdata_q;
  logic              any_req;

  assign any_req = bus.p0_req | bus.p1_req;

`ifdef ROUND_ROBIN_EN
  logic last_q;

  always_comb begin
    win_d = ~bus.p0_req;
    if (bus.p0_req && bus.p1_req) win_d = ~last_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                        last_q <= 1'b1;
    else if (state_q == IDLE && any_req) last_q <= win_d;
  end
`else
  assign win_d = ~bus.p0_req;
`endif

  // RAM-side strobes come straight from flops so the level-sensitive write never glitches.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      done_q      <= '0;
      win_q       <= 1'b0;
      ram_sel_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      gnt_q     <= '0;
      done_q    <= '0;
      ram_sel_q <= 1'b0;
      ram_wr_q  <= 1'b0;
      case (state_q)
        IDLE: if (any_req) begin
          state_q     <= ACCESS;
          win_q       <= win_d;
          gnt_q       <= win_d ? 2'b10 : 2'b01;
          ram_sel_q   <= 1'b1;
          ram_wr_q    <= win_d ? bus.p1_we    : bus.p0_we;
          ram_addr_q  <= win_d ? bus.p1_addr  : bus.p0_addr;
          ram_wdata_q <= win_d ? bus.p1_wdata : bus.p0_wdata;
        end
        ACCESS: begin
          state_q <= RESP;
          if (!ram_wr_q) rdata_q <= bus.ram_rdata;
          done_q  <= win_q ? 2'b10 : 2'b01;
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.p0_gnt     = gnt_q[0];
  assign bus.p1_gnt     = gnt_q[1];
  assign bus.p0_done    = done_q[0];
  assign bus.p1_done    = done_q[1];
  assign bus.rdata      = rdata_q;
  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_write  = ram_wr_q;
  assign bus.ram_select = ram_sel_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model (access windows + reference memory)
// checked every cycle, plus directed latency/priority/reset scenarios.
module tb_mem_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));

  // requester drive
  logic [1:0]    req, we;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd   [2];
  assign bus.p0_req   = req[0];
  assign bus.p1_req   = req[1];
  assign bus.p0_we    = we[0];
  assign bus.p1_we    = we[1];
  assign bus.p0_addr  = addr[0];
  assign bus.p1_addr  = addr[1];
  assign bus.p0_wdata = wd[0];
  assign bus.p1_wdata = wd[1];

  // RAM: combinational read, write on edge while selected; backdoor for preload
  logic [DW-1:0] ram [256];
  logic          bd_we;
  logic [7:0]    bd_a;
  logic [DW-1:0] bd_d;
  assign bus.ram_rdata = ram[bus.ram_addr[7:0]];
  always @(posedge clock) begin
    if (bus.ram_select && bus.ram_write) ram[bus.ram_addr[7:0]] <= bus.ram_wdata;
    else if (bd_we)                      ram[bd_a] <= bd_d;
  end

  // reference model state
  logic [DW-1:0] refmem [256];
  int            cyc = 0, act_cyc = -100, free_at = 0;
  logic          a_w = 1'b0, a_we = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wd = '0, model_rdata = '0;
`ifdef ROUND_ROBIN_EN
  int            lastg = 1;
`endif

  int checks = 0, failures = 0;
  int wr_cnt = 0, busy_cnt = 0, gnt_cnt = 0, done_cnt = 0, last_gnt_cyc = 0;
  int gseq [$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // An access accepted at edge k occupies cycle k (grant) and k+1 (done); next pick at k+3.
  task automatic model_edge();
    cyc++;
    if (!reset_n) begin
      act_cyc = -100; free_at = 0; model_rdata = '0;
`ifdef ROUND_ROBIN_EN
      lastg = 1;
`endif
    end else begin
      if (cyc == act_cyc + 1) begin
        if (a_we) refmem[a_addr[7:0]] = a_wd;
        else      model_rdata = refmem[a_addr[7:0]];
      end
      if (cyc >= free_at && (req[0] || req[1])) begin
        if (req[0] && req[1]) begin
`ifdef ROUND_ROBIN_EN
          a_w = (lastg == 0);
`else
          a_w = 1'b0;
`endif
        end else a_w = req[1];
`ifdef ROUND_ROBIN_EN
        lastg = a_w ? 1 : 0;
`endif
        act_cyc = cyc; free_at = cyc + 3;
        a_we = we[a_w]; a_addr = addr[a_w]; a_wd = wd[a_w];
      end
    end
  endtask

  task automatic check_outputs();
    bit acc, rsp;
    acc = reset_n && (cyc == act_cyc);
    rsp = reset_n && (cyc == act_cyc + 1);
    chk("p0_gnt",     bus.p0_gnt,     acc && !a_w);
    chk("p1_gnt",     bus.p1_gnt,     acc &&  a_w);
    chk("p0_done",    bus.p0_done,    rsp && !a_w);
    chk("p1_done",    bus.p1_done,    rsp &&  a_w);
    chk("ram_select", bus.ram_select, acc);
    chk("ram_write",  bus.ram_write,  acc && a_we);
    chk("busy",       bus.busy,       acc || rsp);
    chk("rdata",      bus.rdata,      model_rdata);
    if (acc) begin
      chk("ram_addr", bus.ram_addr, a_addr);
      if (a_we) chk("ram_wdata", bus.ram_wdata, a_wd);
    end
    if (bus.ram_write) wr_cnt++;
    if (bus.busy) busy_cnt++;
    if (bus.p0_done || bus.p1_done) done_cnt++;
    if (bus.p0_gnt || bus.p1_gnt) begin
      gnt_cnt++;
      gseq.push_back(bus.p1_gnt ? 1 : 0);
      last_gnt_cyc = cyc;
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic idle(int n);
    req = '0;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic directed_access(int p, bit w, logic [AW-1:0] a, logic [DW-1:0] d,
                                 logic [DW-1:0] exp_rdata);
    req[p] = 1'b1; we[p] = w; addr[p] = a; wd[p] = d;
    step();
    chk("gnt_T1", p ? bus.p1_gnt : bus.p0_gnt, 1);
    req[p] = 1'b0;
    step();
    chk("done_T2", p ? bus.p1_done : bus.p0_done, 1);
    if (!w) chk("rdata_T2", bus.rdata, exp_rdata);
    step();
  endtask

  task automatic new_op(int p);
    req[p]  = 1'b1;
    we[p]   = 1'($urandom_range(0, 1));
    addr[p] = AW'($urandom_range(0, 15));
    wd[p]   = $urandom();
  endtask

  task automatic drive_random();
    for (int p = 0; p < 2; p++) begin
      logic g;
      g = p ? bus.p1_gnt : bus.p0_gnt;
      if (!req[p]) begin
        if ($urandom_range(0, 2) == 0) new_op(p);
      end else if (g) begin
        if ($urandom_range(0, 1) == 0) req[p] = 1'b0;
        else                           new_op(p);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wd[0] = '0; wd[1] = '0;
    bd_we = 1'b0; bd_a = '0; bd_d = '0;
    reset_n = 1'b0;

    for (int a = 0; a <= 16; a++) begin
      @(negedge clock);
      bd_we = 1'b1;
      bd_a  = 8'(a);
      bd_d  = (a == 4) ? 32'h1234_5678 : {16'hA5A5, 16'(a)};
      refmem[a] = bd_d;
    end
    @(negedge clock);
    bd_we = 1'b0;

    // reset state, then release: first edge with reset_n high may arbitrate
    step();
    step();
    reset_n = 1'b1;
    idle(2);

    // write then read back through p1
    wr_cnt = 0;
    directed_access(1, 1'b1, 16'h0010, 32'hDEAD_BEEF, '0);
    directed_access(1, 1'b0, 16'h0010, '0, 32'hDEAD_BEEF);
    chk("write_pulse_cycles", wr_cnt, 1);

    // single preloaded read through p0
    idle(2);
    busy_cnt = 0; done_cnt = 0;
    directed_access(0, 1'b0, 16'h0004, '0, 32'h1234_5678);
    chk("busy_cycles", busy_cnt, 2);
    chk("p0_done_count", done_cnt, 1);

    // request held through ACCESS/RESP yields exactly one more access, 3 cycles later
    idle(2);
    gnt_cnt = 0; done_cnt = 0; first = -1;
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0003;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.p0_gnt && first < 0) first = cyc;
      if (gnt_cnt == 2) req[0] = 1'b0;
    end
    chk("hold_grants", gnt_cnt, 2);
    chk("hold_spacing", last_gnt_cyc - first, 3);
    chk("hold_dones", done_cnt, 2);

    // contention: both hold requests for 6 grants
    do_reset();
    gseq.delete(); gnt_cnt = 0;
    req = 2'b11; we = 2'b00; addr[0] = 16'h0001; addr[1] = 16'h0002;
    for (int i = 0; i < 40 && gnt_cnt < 6; i++) step();
    req = '0;
    chk("contention_grants", gnt_cnt, 6);
    for (int i = 0; i < 6 && i < gseq.size(); i++) begin
`ifdef ROUND_ROBIN_EN
      chk("contention_order", gseq[i], i % 2);
`else
      chk("contention_order", gseq[i], 0);
`endif
    end

    // async reset in the middle of a write access
    idle(3);
    done_cnt = 0;
    req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0005; wd[1] = 32'hCAFE_F00D;
    step();
    chk("pre_reset_select", bus.ram_select, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_ram_select", bus.ram_select, 0);
    chk("arst_ram_write",  bus.ram_write, 0);
    chk("arst_p1_gnt",     bus.p1_gnt, 0);
    chk("arst_busy",       bus.busy, 0);
    chk("arst_rdata",      bus.rdata, 0);
    req = '0;
    @(negedge clock);
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("arst_no_done", done_cnt, 0);
    chk("arst_idle", bus.busy, 0);

    // randomized traffic against the model
    do_reset();
    for (int i = 0; i < 500; i++) begin
      step();
      drive_random();
    end
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
